// File: rtl/refresh_counter_pkg.sv
// Shared defaults and the debt-update encoding for the DRAM refresh counter.
package refresh_counter_pkg;

    localparam int REF_PERIOD_DEF  = 375;
    localparam int DEBT_MAX_DEF    = 7;
    localparam int URGENT_DEBT_DEF = 2;
    localparam int URGENT_AGE_DEF  = 250;
    localparam int DEBT_W          = 3;

    typedef enum logic [1:0] {
        DEBT_HOLD,
        DEBT_INC,
        DEBT_DEC
    } debt_op_e;

    // A tick and an ack edge in the same cycle cancel: that tick's refresh is the one served.
    function automatic debt_op_e debt_op(input logic tick, input logic ack_edge);
        debt_op_e op;
        op = DEBT_HOLD;
        if (tick && !ack_edge) begin
            op = DEBT_INC;
        end else if (!tick && ack_edge) begin
            op = DEBT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running 0..REF_PERIOD-1 divider; Tick marks the wrap cycle and the count freezes while disabled.
module refresh_prescaler
    import refresh_counter_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic CLK,
    input  logic nRES,
    input  logic RefEn,
    output logic Tick
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

    logic [CW-1:0] count;

    assign Tick = RefEn && (count == LAST);

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            count <= '0;
        end else if (RefEn) begin
            count <= Tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/refresh_counter.sv
// Tracks owed DRAM refreshes: ticks add debt, ack rising edges pay it off, age/debt raise urgency.
module refresh_counter
    import refresh_counter_pkg::*;
#(
    parameter int REF_PERIOD  = REF_PERIOD_DEF,
    parameter int DEBT_MAX    = DEBT_MAX_DEF,
    parameter int URGENT_DEBT = URGENT_DEBT_DEF,
    parameter int URGENT_AGE  = URGENT_AGE_DEF
) (
    input  logic              CLK,
    input  logic              nRES,
    input  logic              RefEn,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrgent,
    output logic [DEBT_W-1:0] Debt,
    output logic              Overrun
);

    localparam int AW = (URGENT_AGE > 0) ? $clog2(URGENT_AGE + 1) : 1;
    localparam logic [DEBT_W-1:0] DMAX  = DEBT_W'(DEBT_MAX);
    localparam logic [DEBT_W-1:0] UDEBT = DEBT_W'(URGENT_DEBT);
    localparam logic [AW-1:0]     AMAX  = AW'(URGENT_AGE);

    logic          tick;
    logic          ack_prev;
    logic          ack_armed;
    logic          ack_edge;
    logic [AW-1:0] age;
    debt_op_e      op;

    refresh_prescaler #(
        .REF_PERIOD(REF_PERIOD)
    ) u_prescaler (
        .CLK   (CLK),
        .nRES  (nRES),
        .RefEn (RefEn),
        .Tick  (tick)
    );

    // ack_armed blocks an ack that is already high across reset release until it has been seen low.
    always_comb begin
        ack_edge = RefAck && !ack_prev && ack_armed;
        op       = debt_op(tick, ack_edge);
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            ack_prev  <= 1'b0;
            ack_armed <= !RefAck;
            Debt      <= '0;
            age       <= '0;
            Overrun   <= 1'b0;
        end else begin
            ack_prev  <= RefAck;
            ack_armed <= ack_armed || !RefAck;

            unique case (op)
                DEBT_INC: begin
                    if (Debt == DMAX) Overrun <= 1'b1;
                    else              Debt    <= Debt + DEBT_W'(1);
                end
                DEBT_DEC: begin
                    if (Debt == '0) Overrun <= 1'b1;
                    else            Debt    <= Debt - DEBT_W'(1);
                end
                default: ;
            endcase

            if (ack_edge || Debt == '0) begin
                age <= '0;
            end else if (age != AMAX) begin
                age <= age + AW'(1);
            end
        end
    end

    assign RefReq    = (Debt != '0);
    assign RefUrgent = (Debt >= UDEBT) || (age == AMAX);

endmodule

// File: tb/tb_refresh_counter.sv
// Directed bench for refresh_counter with REF_PERIOD=8 and URGENT_AGE=20.
module tb_refresh_counter;

    logic       CLK;
    logic       nRES;
    logic       RefEn;
    logic       RefAck;
    logic       RefReq;
    logic       RefUrgent;
    logic [2:0] Debt;
    logic       Overrun;

    int checks;
    int errors;

    refresh_counter #(
        .REF_PERIOD (8),
        .URGENT_AGE (20)
    ) dut (
        .CLK       (CLK),
        .nRES      (nRES),
        .RefEn     (RefEn),
        .RefAck    (RefAck),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .Debt      (Debt),
        .Overrun   (Overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n posedges; outputs are then sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] d, input logic req,
                           input logic urg, input logic ovr);
        chk({tag, ".debt"},    32'(Debt),      32'(d));
        chk({tag, ".req"},     32'(RefReq),    32'(req));
        chk({tag, ".urgent"},  32'(RefUrgent), 32'(urg));
        chk({tag, ".overrun"}, 32'(Overrun),   32'(ovr));
    endtask

    task automatic apply_reset(input string tag);
        nRES = 1'b0;
        step(1);
        chk_all(tag, 3'd0, 1'b0, 1'b0, 1'b0);
        nRES = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRES   = 1'b0;
        RefEn  = 1'b1;
        RefAck = 1'b0;

        // Ticks accumulate from reset release
        apply_reset("rst0");
        step(7);
        chk_all("pre_tick", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("tick1", 3'd1, 1'b1, 1'b0, 1'b0);
        step(7);
        chk("pre_tick2", 32'(Debt), 32'd1);
        step(1);
        chk_all("tick2", 3'd2, 1'b1, 1'b1, 1'b0);

        // Prescaler frozen; one ack brings debt to 1, then age urgency
        RefEn  = 1'b0;
        RefAck = 1'b1;
        step(1);
        chk_all("ack_to1", 3'd1, 1'b1, 1'b0, 1'b0);
        RefAck = 1'b0;
        step(1);
        step(18);
        chk_all("age19", 3'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("age20", 3'd1, 1'b1, 1'b1, 1'b0);
        step(2);
        chk("age_sat", 32'(RefUrgent), 32'd1);

        // Two-cycle ack pulse credits exactly once
        RefAck = 1'b1;
        step(1);
        chk_all("pulse_hi1", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("pulse_hi2", 3'd0, 1'b0, 1'b0, 1'b0);
        RefAck = 1'b0;
        step(1);

        // Ack edge coinciding with tick at debt 3
        RefEn = 1'b1;
        apply_reset("rst1");
        step(24);
        chk_all("debt3", 3'd3, 1'b1, 1'b1, 1'b0);
        step(7);
        RefAck = 1'b1;
        step(1);
        chk_all("tick_ack", 3'd3, 1'b1, 1'b1, 1'b0);
        RefAck = 1'b0;
        step(1);

        // Saturation, overrun, ack after saturation, mid-run reset
        apply_reset("rst2");
        step(56);
        chk_all("debt7", 3'd7, 1'b1, 1'b1, 1'b0);
        step(8);
        chk_all("sat_ovr", 3'd7, 1'b1, 1'b1, 1'b1);
        RefAck = 1'b1;
        step(1);
        chk_all("ack_sat", 3'd6, 1'b1, 1'b1, 1'b1);
        RefAck = 1'b0;
        step(1);
        apply_reset("rst3");

        // Ack high across reset release is not an edge
        RefEn  = 1'b0;
        RefAck = 1'b1;
        apply_reset("rst4");
        step(3);
        chk_all("ack_held", 3'd0, 1'b0, 1'b0, 1'b0);
        RefAck = 1'b0;
        step(1);
        RefAck = 1'b1;
        step(1);
        chk_all("ack_zero", 3'd0, 1'b0, 1'b0, 1'b1);
        RefAck = 1'b0;
        step(2);
        chk("ovr_sticky", 32'(Overrun), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
